// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register between ID and WB.
// Latency: stall is combinational from current state; issue/retire/flush take effect at the next edge.
// Backpressure: stall holds ID on an unresolved source hazard or a saturated per-register counter.
// Optional build macro SCOREBOARD_FWD_EN: with it, source hazards stall only on a pending load producer.
module reg_scoreboard #(
  parameter int CNT_WIDTH = 2,
  parameter int REG_NUM   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reg_read_en_1,
  input  logic [4:0] reg_addr_1,
  input  logic       reg_read_en_2,
  input  logic [4:0] reg_addr_2,
  input  logic       reg_write_en,
  input  logic [4:0] reg_write_addr,
  input  logic       id_is_load,
  input  logic       id_issue,
  input  logic       wb_write_en,
  input  logic [4:0] wb_write_addr,
  input  logic       flush,
  output logic       stall,
  output logic [5:0] busy_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Per-register outstanding-write count and "latest producer is a load" flag.
  logic [CNT_WIDTH-1:0] cnt_q [REG_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [REG_NUM];
  logic [REG_NUM-1:0]   ld_q;
  logic [REG_NUM-1:0]   ld_d;
  logic [5:0]           busy_count_q;
  logic [5:0]           busy_count_d;

  logic src_hazard_1;
  logic src_hazard_2;
  logic full_hazard;
  logic issue_eff;
  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;

  // Source and capacity hazards from current state only; WB of this cycle is not bypassed.
  always_comb begin
    src_hazard_1 = 1'b0;
    src_hazard_2 = 1'b0;
    full_hazard  = 1'b0;
`ifdef SCOREBOARD_FWD_EN
    // Non-load producers are forwarded from EX/MEM, so only a pending load blocks a reader.
    src_hazard_1 = reg_read_en_1 && (reg_addr_1 != 5'd0) &&
                   (cnt_q[reg_addr_1] != CNT_ZERO) && ld_q[reg_addr_1];
    src_hazard_2 = reg_read_en_2 && (reg_addr_2 != 5'd0) &&
                   (cnt_q[reg_addr_2] != CNT_ZERO) && ld_q[reg_addr_2];
`else
    // No forwarding network: any pending producer blocks a reader.
    src_hazard_1 = reg_read_en_1 && (reg_addr_1 != 5'd0) &&
                   (cnt_q[reg_addr_1] != CNT_ZERO);
    src_hazard_2 = reg_read_en_2 && (reg_addr_2 != 5'd0) &&
                   (cnt_q[reg_addr_2] != CNT_ZERO);
`endif
    // A saturated counter cannot take another producer without wrapping.
    full_hazard  = reg_write_en && (reg_write_addr != 5'd0) &&
                   (cnt_q[reg_write_addr] == CNT_MAX);
  end

  assign stall     = src_hazard_1 | src_hazard_2 | full_hazard;
  assign issue_eff = id_issue && !stall && !flush;

  // Decode per-register increment (accepted issue) and decrement (retire of a pending write).
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc_vec[r] = issue_eff && reg_write_en && (reg_write_addr == 5'(r));
      dec_vec[r] = wb_write_en && (wb_write_addr == 5'(r)) && (cnt_q[r] != CNT_ZERO);
    end
  end

  // Next-state counters, load flags and the popcount of busy registers.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    ld_d         = ld_q;
    busy_count_d = 6'd0;

    for (int r = 1; r < REG_NUM; r++) begin
      if (inc_vec[r] && dec_vec[r]) begin
        // One retires while another enters: count unchanged, newest producer owns the flag.
        ld_d[r] = id_is_load;
      end else if (inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
        ld_d[r]  = id_is_load;
      end else if (dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
        if (cnt_q[r] == CNT_ONE) begin
          ld_d[r] = 1'b0;
        end
      end
    end

    // Flush overrides any issue or retire in the same cycle.
    if (flush) begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_d[r] = CNT_ZERO;
      end
      ld_d = '0;
    end

    // Register 0 is hardwired zero and never tracked.
    cnt_d[0] = CNT_ZERO;
    ld_d[0]  = 1'b0;

    for (int r = 1; r < REG_NUM; r++) begin
      if (cnt_d[r] != CNT_ZERO) begin
        busy_count_d = busy_count_d + 6'd1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      ld_q         <= '0;
      busy_count_q <= 6'd0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ld_q         <= ld_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed test-plan steps followed by random traffic,
// each cycle compared against a per-register counting model of in-flight writes.
module tb_reg_scoreboard;

  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_read_en_1, reg_read_en_2, reg_write_en, id_is_load, id_issue;
  logic       wb_write_en, flush;
  logic [4:0] reg_addr_1, reg_addr_2, reg_write_addr, wb_write_addr;
  logic       stall;
  logic [5:0] busy_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending write count and load-ness of the newest producer.
  int m_cnt [32];
  bit m_ld  [32];

  reg_scoreboard #(.CNT_WIDTH(2), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .reg_read_en_1(reg_read_en_1), .reg_addr_1(reg_addr_1),
    .reg_read_en_2(reg_read_en_2), .reg_addr_2(reg_addr_2),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .id_is_load(id_is_load), .id_issue(id_issue),
    .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr),
    .flush(flush), .stall(stall), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  function automatic bit src_blocks(bit en, logic [4:0] a);
`ifdef SCOREBOARD_FWD_EN
    return en && a != 0 && m_cnt[a] > 0 && m_ld[a];
`else
    return en && a != 0 && m_cnt[a] > 0;
`endif
  endfunction

  function automatic bit model_stall();
    bit full;
    full = reg_write_en && reg_write_addr != 0 && m_cnt[reg_write_addr] == CNT_MAX;
    return src_blocks(reg_read_en_1, reg_addr_1) || src_blocks(reg_read_en_2, reg_addr_2) || full;
  endfunction

  function automatic int model_busy();
    int n = 0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_ld[r]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step(bit stalled);
    bit inc, dec;
    int ia, da;
    if (flush) begin
      model_clear();
      return;
    end
    inc = id_issue && !stalled && reg_write_en && reg_write_addr != 0;
    ia  = reg_write_addr;
    dec = wb_write_en && wb_write_addr != 0 && m_cnt[wb_write_addr] > 0;
    da  = wb_write_addr;
    if (inc && dec && ia == da) begin
      m_ld[ia] = id_is_load;
    end else begin
      if (dec) begin
        m_cnt[da]--;
        if (m_cnt[da] == 0) m_ld[da] = 0;
      end
      if (inc) begin
        m_cnt[ia]++;
        m_ld[ia] = id_is_load;
      end
    end
  endtask

  task automatic apply(bit re1, int a1, bit re2, int a2, bit we, int wa, bit ld,
                       bit iss, bit wbe, int wba, bit fl);
    reg_read_en_1 = re1; reg_addr_1 = 5'(a1);
    reg_read_en_2 = re2; reg_addr_2 = 5'(a2);
    reg_write_en = we; reg_write_addr = 5'(wa); id_is_load = ld;
    id_issue = iss; wb_write_en = wbe; wb_write_addr = 5'(wba); flush = fl;
  endtask

  // Check stall mid-cycle, clock once, then check busy_count just after the edge.
  task automatic cycle(string tag);
    bit exp_stall;
    int exp_busy;
    #1;
    exp_stall = model_stall();
    n_cmp++;
    assert (stall === exp_stall) else begin
      n_err++;
      $error("FAIL %s stall: got %0b expected %0b", tag, stall, exp_stall);
    end
    model_step(exp_stall);
    @(posedge clk);
    #1;
    exp_busy = model_busy();
    n_cmp++;
    assert (busy_count === 6'(exp_busy)) else begin
      n_err++;
      $error("FAIL %s busy_count: got %0d expected %0d", tag, busy_count, exp_busy);
    end
  endtask

  initial begin
    model_clear();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    assert (stall === 1'b0 && busy_count === 6'd0) else begin
      n_err++;
      $error("FAIL reset: stall %0b busy %0d expected 0/0", stall, busy_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read with nothing pending.
    apply(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle("idle_read");

    // ALU producer of $8, then a reader, then retire.
    apply(0, 0, 0, 0, 1, 8, 0, 1, 0, 0, 0); cycle("issue_r8");
    apply(0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0); cycle("read_r8_pending");
    apply(0, 0, 1, 8, 0, 0, 0, 0, 1, 8, 0); cycle("wb_r8");
    apply(0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0); cycle("read_r8_done");

    // Load producer of $9; reader tries to issue while stalled.
    apply(0, 0, 0, 0, 1, 9, 1, 1, 0, 0, 0); cycle("issue_lw_r9");
    apply(1, 9, 0, 0, 1, 7, 0, 1, 0, 0, 0); cycle("lw_use_1");
    apply(1, 9, 0, 0, 1, 7, 0, 1, 0, 0, 0); cycle("lw_use_2");
    apply(1, 9, 0, 0, 1, 7, 0, 1, 1, 9, 0); cycle("wb_r9");
    apply(1, 9, 0, 0, 1, 7, 0, 1, 0, 0, 0); cycle("lw_use_go");
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle("wb_r7");

    // Saturate $3, then a fourth writer hits the capacity limit.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0); cycle("fill_r3");
    end
    apply(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0); cycle("full_r3");
    apply(0, 0, 0, 0, 1, 3, 0, 1, 1, 3, 0); cycle("full_r3_wb");
    apply(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 0); cycle("full_r3_go");
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0); cycle("drain_r3");
    end

    // Same-cycle issue/retire, retire of idle registers, write to $0.
    apply(0, 0, 0, 0, 1, 4, 0, 1, 0, 0, 0); cycle("issue_r4");
    apply(0, 0, 0, 0, 1, 4, 1, 1, 1, 4, 0); cycle("issue_wb_r4");
    apply(1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("wb_r0");
    apply(1, 4, 0, 0, 0, 0, 0, 0, 1, 6, 0); cycle("wb_r6_idle");
    apply(0, 0, 0, 0, 1, 0, 1, 1, 1, 4, 0); cycle("write_r0");
    apply(1, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0); cycle("after_r4");

    // Two pending, then flush racing an issue.
    apply(0, 0, 0, 0, 1, 10, 1, 1, 0, 0, 0); cycle("issue_r10");
    apply(0, 0, 0, 0, 1, 11, 1, 1, 0, 0, 0); cycle("issue_r11");
    apply(0, 0, 0, 0, 1, 12, 1, 1, 0, 0, 1); cycle("flush");
    apply(1, 10, 1, 11, 1, 12, 0, 0, 0, 0, 0); cycle("post_flush");

    // Asynchronous reset while stalled.
    apply(0, 0, 0, 0, 1, 13, 1, 1, 0, 0, 0); cycle("issue_r13");
    apply(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    assert (stall === model_stall()) else begin
      n_err++;
      $error("FAIL pre_rst stall: got %0b expected %0b", stall, model_stall());
    end
    rst = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    assert (stall === 1'b0 && busy_count === 6'd0) else begin
      n_err++;
      $error("FAIL mid_rst: stall %0b busy %0d expected 0/0", stall, busy_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic over a small register window to force frequent hazards.
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(1, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(7, 0),
            $urandom_range(3, 0) != 0, $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(3, 0) != 0,
            $urandom_range(1, 0), $urandom_range(7, 0),
            $urandom_range(40, 0) == 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
